// File: rtl/fft_power_pkg.sv
// Shared constants, FSM state type and the component saturation helper
// for the FFT power accumulator.
package fft_power_pkg;

  localparam int LATENCY     = 4;
  localparam int POW_WIDTH   = 32;
  localparam int TRUNC_WIDTH = 16;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  function automatic logic signed [TRUNC_WIDTH-1:0] sat_trunc(input logic signed [31:0] x);
    if (x > 32'sh0000_7fff)      return 16'h7fff;
    else if (x < -32'sh0000_8000) return 16'h8000;
    else                          return x[TRUNC_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fft_power_ram.sv
// Simple dual-port accumulation RAM: one write port, one read port with a
// two-cycle registered read (address register + data register).
module fft_power_ram #(
  parameter int AW = 14,
  parameter int DW = 192
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] rd_addr_q;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_addr_q <= rd_addr;
    rd_data   <= mem[rd_addr_q];
  end

endmodule

// File: rtl/fft_power_accum.sv
// Four-lane |X|^2 accumulator over num_avg frames; the last frame of each
// integration streams the accumulated spectrum out with fixed 4-cycle latency.
//
// state | meaning
// IDLE  | waiting for a valid beat with k=0 to start an integration
// ACCUM | tracking contiguous bin indices and frame count
module fft_power_accum
  import fft_power_pkg::*;
#(
  parameter int K_WIDTH   = 14,
  parameter int ACC_WIDTH = 48,
  parameter int SHIFT     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          data_in_0,
  input  logic [63:0]          data_in_1,
  input  logic [63:0]          data_in_2,
  input  logic [63:0]          data_in_3,
  input  logic [K_WIDTH-1:0]   k,
  input  logic                 s_valid,
  input  logic [15:0]          num_avg,
  output logic [ACC_WIDTH-1:0] m_data_0,
  output logic [ACC_WIDTH-1:0] m_data_1,
  output logic [ACC_WIDTH-1:0] m_data_2,
  output logic [ACC_WIDTH-1:0] m_data_3,
  output logic [K_WIDTH-1:0]   m_k,
  output logic                 m_valid,
  output logic                 m_last,
  output logic                 sync_err,
  output logic                 ovf
);

  localparam int LANES = 4;
  localparam int RAM_W = LANES * ACC_WIDTH;
  localparam logic [K_WIDTH-1:0] K_MAX = '1;

  logic [63:0] din [LANES];
  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign din[2] = data_in_2;
  assign din[3] = data_in_3;

  state_t             state;
  logic [K_WIDTH-1:0] exp_k;
  logic [15:0]        navg, frame_cnt;
  logic [15:0]        num_avg_eff, cur_navg, cur_fc;
  logic               start, hit, miss, accept, first_frame, last_frame;

  // A starting beat sees the freshly sampled num_avg, not the stale navg.
  always_comb begin
    num_avg_eff = (num_avg == 16'd0) ? 16'd1 : num_avg;
    start       = s_valid && (state == IDLE) && (k == '0);
    hit         = s_valid && (state == ACCUM) && (k == exp_k);
    miss        = s_valid && (state == ACCUM) && (k != exp_k);
    accept      = start || hit;
    cur_navg    = start ? num_avg_eff : navg;
    cur_fc      = start ? 16'd0 : frame_cnt;
    first_frame = (cur_fc == 16'd0);
    last_frame  = (cur_fc == cur_navg - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      exp_k     <= '0;
      navg      <= 16'd1;
      frame_cnt <= 16'd0;
      sync_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ACCUM;
            navg      <= num_avg_eff;
            frame_cnt <= 16'd0;
            exp_k     <= K_WIDTH'(1);
          end
        end
        ACCUM: begin
          if (miss) begin
            sync_err <= 1'b1;
            state    <= IDLE;
          end else if (hit) begin
            exp_k <= exp_k + K_WIDTH'(1);
            if (k == K_MAX) begin
              if (frame_cnt + 16'd1 == navg) begin
                frame_cnt <= 16'd0;
                navg      <= num_avg_eff;
              end else begin
                frame_cnt <= frame_cnt + 16'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic signed [TRUNC_WIDTH-1:0] re_c [LANES], im_c [LANES];
  logic signed [TRUNC_WIDTH-1:0] re1 [LANES], im1 [LANES];
  logic [POW_WIDTH-1:0]          sq_re1 [LANES], sq_im1 [LANES];
  logic [POW_WIDTH-1:0]          sq_re2 [LANES], sq_im2 [LANES], p3 [LANES];
  logic                          v1, v2, v3, f1, f2, f3, o1, o2, o3;
  logic [K_WIDTH-1:0]            k1, k2, k3;

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      re_c[j]   = sat_trunc($signed(din[j][31:0]) >>> SHIFT);
      im_c[j]   = sat_trunc($signed(din[j][63:32]) >>> SHIFT);
      sq_re1[j] = $unsigned(POW_WIDTH'(re1[j]) * POW_WIDTH'(re1[j]));
      sq_im1[j] = $unsigned(POW_WIDTH'(im1[j]) * POW_WIDTH'(im1[j]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Data stages run freely; only the valid bits carry meaning.
  always_ff @(posedge clk) begin
    k1 <= k;
    f1 <= first_frame;
    o1 <= last_frame;
    k2 <= k1;
    f2 <= f1;
    o2 <= o1;
    k3 <= k2;
    f3 <= f2;
    o3 <= o2;
    for (int j = 0; j < LANES; j++) begin
      re1[j]    <= re_c[j];
      im1[j]    <= im_c[j];
      sq_re2[j] <= sq_re1[j];
      sq_im2[j] <= sq_im1[j];
      p3[j]     <= sq_re2[j] + sq_im2[j];
    end
  end

  logic [RAM_W-1:0]     rd_data, wr_data;
  logic [ACC_WIDTH-1:0] acc [LANES];
  logic [ACC_WIDTH:0]   sum [LANES];
  logic [LANES-1:0]     sat;

  always_comb begin
    wr_data = '0;
    sat     = '0;
    for (int j = 0; j < LANES; j++) begin
      sum[j] = {1'b0, rd_data[j*ACC_WIDTH +: ACC_WIDTH]} + (ACC_WIDTH+1)'(p3[j]);
      sat[j] = ~f3 & sum[j][ACC_WIDTH];
      if (f3)                  acc[j] = ACC_WIDTH'(p3[j]);
      else if (sum[j][ACC_WIDTH]) acc[j] = '1;
      else                     acc[j] = sum[j][ACC_WIDTH-1:0];
      wr_data[j*ACC_WIDTH +: ACC_WIDTH] = acc[j];
    end
  end

  fft_power_ram #(
    .AW(K_WIDTH),
    .DW(RAM_W)
  ) u_ram (
    .clk    (clk),
    .we     (v3),
    .wr_addr(k3),
    .wr_data(wr_data),
    .rd_addr(k1),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_k      <= '0;
      m_data_0 <= '0;
      m_data_1 <= '0;
      m_data_2 <= '0;
      m_data_3 <= '0;
      ovf      <= 1'b0;
    end else begin
      m_valid <= v3 && o3;
      m_last  <= v3 && o3 && (k3 == K_MAX);
      if (v3 && (|sat)) ovf <= 1'b1;
      if (v3 && o3) begin
        m_k      <= k3;
        m_data_0 <= acc[0];
        m_data_1 <= acc[1];
        m_data_2 <= acc[2];
        m_data_3 <= acc[3];
      end
    end
  end

endmodule
